// File: rtl/llsc_reservation_unit.sv
// MEM-stage LL/SC reservation tracker: owns the linked word address, decides SC success and drives LLbit writes.
// Optional reservation lifetime counter enabled by defining LLSC_TIMEOUT_EN.
module llsc_reservation_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  mem_valid,
  input  logic [1:0]            mem_op,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_we_in,
  input  logic                  LLbit_value,
  input  logic                  wb_LLbit_write_enable,
  input  logic                  wb_LLbit_value,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  mem_we_out,
  output logic                  sc_result,
  output logic                  LLbit_write_enable,
  output logic                  LLbit_write_value,
  output logic                  link_valid,
  output logic [ADDR_WIDTH-3:0] link_addr
);

  localparam int AW = ADDR_WIDTH - 2;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {IDLE, LINKED} state_t;

  state_t state;
  logic   linked, ll_req, sc_req, st_req;
  logic   mem_hit, snoop_hit, eff, expire, active, sc_ok;
  logic   unused_bits;

  assign unused_bits = ^{mem_addr[1:0], snoop_addr[1:0]};

  assign linked     = (state == LINKED);
  assign link_valid = linked;
  assign ll_req     = mem_valid && (mem_op == 2'b01);
  assign sc_req     = mem_valid && (mem_op == 2'b10);
  assign st_req     = mem_valid && (mem_op == 2'b11);
  assign mem_hit    = (mem_addr[ADDR_WIDTH-1:2] == link_addr);
  assign snoop_hit  = linked && snoop_valid && (snoop_addr[ADDR_WIDTH-1:2] == link_addr);
  assign eff        = wb_LLbit_write_enable ? wb_LLbit_value : LLbit_value;
  assign active     = mem_valid && !flush && !reset;

`ifdef LLSC_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] age;

  assign expire = linked && !stall && (age == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      age <= '0;
    end else if (!flush && !stall) begin
      if (ll_req)      age <= '0;
      else if (linked) age <= age + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // A same-cycle snoop hit or lifetime expiry both defeat the SC.
  assign sc_ok = eff && linked && !expire && mem_hit && !snoop_hit;

  always_comb begin
    mem_we_out         = 1'b0;
    sc_result          = 1'b0;
    LLbit_write_enable = 1'b0;
    LLbit_write_value  = 1'b0;
    if (active) begin
      case (mem_op)
        2'b01: begin
          LLbit_write_enable = 1'b1;
          LLbit_write_value  = 1'b1;
        end
        2'b10: begin
          mem_we_out         = mem_we_in && sc_ok;
          sc_result          = sc_ok;
          LLbit_write_enable = 1'b1;
        end
        2'b11: begin
          mem_we_out         = mem_we_in;
          LLbit_write_enable = (linked && mem_hit) || snoop_hit || expire;
        end
        default: LLbit_write_enable = snoop_hit || expire;
      endcase
    end
  end

  // Snoop hits clear the link even while stalled so no remote write is missed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      link_addr <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (stall) begin
      if (snoop_hit) state <= IDLE;
    end else if (ll_req) begin
      state     <= LINKED;
      link_addr <= mem_addr[ADDR_WIDTH-1:2];
    end else if (sc_req || (st_req && mem_hit) || snoop_hit || expire) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// Directed bench for llsc_reservation_unit; the lifetime section runs only when LLSC_TIMEOUT_EN is defined.
module tb_llsc_reservation_unit;

`ifdef LLSC_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, stall, mem_valid, mem_we_in;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr, snoop_addr;
  logic        LLbit_value, wb_LLbit_write_enable, wb_LLbit_value, snoop_valid;
  logic        mem_we_out, sc_result, LLbit_write_enable, LLbit_write_value, link_valid;
  logic [29:0] link_addr;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  llsc_reservation_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .flush(flush), .stall(stall),
    .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr), .mem_we_in(mem_we_in),
    .LLbit_value(LLbit_value), .wb_LLbit_write_enable(wb_LLbit_write_enable),
    .wb_LLbit_value(wb_LLbit_value), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .mem_we_out(mem_we_out), .sc_result(sc_result), .LLbit_write_enable(LLbit_write_enable),
    .LLbit_write_value(LLbit_write_value), .link_valid(link_valid), .link_addr(link_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns all MEM-side inputs to a quiet state: no instruction, no snoop, eff LLbit = 1.
  task automatic quiet();
    flush = 0; stall = 0; mem_valid = 0; mem_op = 2'b00; mem_addr = 0; mem_we_in = 0;
    LLbit_value = 1; wb_LLbit_write_enable = 0; wb_LLbit_value = 0;
    snoop_valid = 0; snoop_addr = 0;
  endtask

  task automatic op(input logic [1:0] o, input logic [31:0] a, input logic we);
    quiet();
    mem_valid = 1; mem_op = o; mem_addr = a; mem_we_in = we;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic outs(input string tag, input logic we, input logic sc, input logic lwe, input logic lval);
    check({tag, ".mem_we_out"}, 32'(mem_we_out), 32'(we));
    check({tag, ".sc_result"}, 32'(sc_result), 32'(sc));
    check({tag, ".LLbit_we"}, 32'(LLbit_write_enable), 32'(lwe));
    check({tag, ".LLbit_val"}, 32'(LLbit_write_value), 32'(lval));
  endtask

  initial begin
    reset = 1;
    op(2'b10, 32'h100, 1'b1);
    settle();
    outs("reset_sc", 0, 0, 0, 0);
    step();
    check("reset.link_valid", 32'(link_valid), 0);
    check("reset.link_addr", 32'(link_addr), 0);
    reset = 0;

    // LL then successful SC
    op(2'b01, 32'h100, 1'b0); settle();
    outs("ll100", 0, 0, 1, 1);
    step();
    check("ll100.link_valid", 32'(link_valid), 1);
    check("ll100.link_addr", 32'(link_addr), 32'h40);
    op(2'b10, 32'h100, 1'b1); settle();
    outs("sc100_ok", 1, 1, 1, 0);
    step();
    check("sc100_ok.link_valid", 32'(link_valid), 0);

    // Snoop to the same word between LL and SC
    op(2'b01, 32'h100, 1'b0); step();
    op(2'b00, 32'h0, 1'b0); snoop_valid = 1; snoop_addr = 32'h102; settle();
    outs("snoop102", 0, 0, 1, 0);
    step();
    check("snoop102.link_valid", 32'(link_valid), 0);
    op(2'b10, 32'h100, 1'b1); settle();
    outs("sc_after_snoop", 0, 0, 1, 0);
    step();

    // SC to a different word
    op(2'b01, 32'h100, 1'b0); step();
    op(2'b10, 32'h104, 1'b1); settle();
    outs("sc104_miss", 0, 0, 1, 0);
    step();
    check("sc104_miss.link_valid", 32'(link_valid), 0);

    // LL squashed by flush
    op(2'b01, 32'h200, 1'b0); flush = 1; settle();
    outs("ll200_flush", 0, 0, 0, 0);
    step();
    check("ll200_flush.link_valid", 32'(link_valid), 0);
    op(2'b10, 32'h200, 1'b1); settle();
    outs("sc200_after_flush", 0, 0, 1, 0);
    step();

    // WB forwarding of LLbit
    op(2'b01, 32'h300, 1'b0); step();
    op(2'b10, 32'h300, 1'b1); LLbit_value = 1; wb_LLbit_write_enable = 1; wb_LLbit_value = 0; settle();
    outs("fwd_clear", 0, 0, 1, 0);
    step();
    op(2'b01, 32'h300, 1'b0); step();
    op(2'b10, 32'h300, 1'b1); LLbit_value = 0; wb_LLbit_write_enable = 1; wb_LLbit_value = 1; settle();
    outs("fwd_set", 1, 1, 1, 0);
    step();

    // Snoop hit in the same cycle as SC
    op(2'b01, 32'h400, 1'b0); step();
    op(2'b10, 32'h400, 1'b1); snoop_valid = 1; snoop_addr = 32'h400; settle();
    outs("sc_snoop_same", 0, 0, 1, 0);
    step();

    // Snoop hit in the same cycle as LL to that address: LL wins
    op(2'b01, 32'h500, 1'b0); step();
    op(2'b01, 32'h500, 1'b0); snoop_valid = 1; snoop_addr = 32'h501; settle();
    outs("ll_snoop_same", 0, 0, 1, 1);
    step();
    check("ll_snoop_same.link_valid", 32'(link_valid), 1);

    // Snoop during stall still clears the link
    op(2'b10, 32'h500, 1'b1); stall = 1; snoop_valid = 1; snoop_addr = 32'h500; step();
    check("stall_snoop.link_valid", 32'(link_valid), 0);

    // Stall holds the link address against a new LL
    op(2'b01, 32'h600, 1'b0); step();
    op(2'b01, 32'h700, 1'b0); stall = 1; step();
    check("stall_ll.link_addr", 32'(link_addr), 32'h180);
    check("stall_ll.link_valid", 32'(link_valid), 1);

    // Ordinary stores: miss keeps the link, hit clears it
    op(2'b11, 32'h700, 1'b1); settle();
    outs("store_miss", 1, 0, 0, 0);
    step();
    check("store_miss.link_valid", 32'(link_valid), 1);
    op(2'b11, 32'h603, 1'b1); settle();
    outs("store_hit", 1, 0, 1, 0);
    step();
    check("store_hit.link_valid", 32'(link_valid), 0);

    // LL reload moves the link
    op(2'b01, 32'h800, 1'b0); step();
    op(2'b01, 32'h900, 1'b0); step();
    check("reload.link_addr", 32'(link_addr), 32'h240);
    op(2'b10, 32'h800, 1'b1); settle();
    outs("sc_old_addr", 0, 0, 1, 0);
    step();

    // Flush kills a live link; mem_valid=0 silences outputs
    op(2'b01, 32'hA00, 1'b0); step();
    op(2'b00, 32'h0, 1'b0); flush = 1; step();
    check("flush_kill.link_valid", 32'(link_valid), 0);
    op(2'b10, 32'hA00, 1'b1); mem_valid = 0; settle();
    outs("invalid_sc", 0, 0, 0, 0);
    step();

    // Reset arriving with an SC in MEM
    op(2'b01, 32'hB00, 1'b0); step();
    op(2'b10, 32'hB00, 1'b1); reset = 1; settle();
    outs("reset_mid_sc", 0, 0, 0, 0);
    step();
    check("reset_mid.link_valid", 32'(link_valid), 0);
    check("reset_mid.link_addr", 32'(link_addr), 0);
    reset = 0;

    // Without a lifetime limit the link survives many idle cycles
    op(2'b01, 32'hC00, 1'b0); step();
    op(2'b00, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) step();
`ifndef LLSC_TIMEOUT_EN
    check("persist.link_valid", 32'(link_valid), 1);
    op(2'b10, 32'hC00, 1'b1); settle();
    outs("persist_sc", 1, 1, 1, 0);
    step();
`else
    check("expired.link_valid", 32'(link_valid), 0);
    op(2'b10, 32'hC00, 1'b1); settle();
    outs("expired_sc", 0, 0, 1, 0);
    step();

    // Expiry on the eighth cycle after the LL
    op(2'b01, 32'hD00, 1'b0); step();
    op(2'b00, 32'h0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      settle();
      check($sformatf("age%0d.LLbit_we", i), 32'(LLbit_write_enable), 0);
      step();
    end
    settle();
    outs("age8_expire", 0, 0, 1, 0);
    step();
    check("age8.link_valid", 32'(link_valid), 0);

    // SC at the fifth cycle after LL still succeeds
    op(2'b01, 32'hE00, 1'b0); step();
    op(2'b00, 32'h0, 1'b0);
    for (int i = 1; i < 5; i++) step();
    op(2'b10, 32'hE00, 1'b1); settle();
    outs("sc_age5", 1, 1, 1, 0);
    step();
`endif

    quiet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/llsc_reservation_unit.md
Name: llsc_reservation_unit

Overview:
MEM-stage controller for MIPS LL/SC atomics.
- Consumes the LLbit value held by the LLbit register, with forwarding from WB, and produces that register's write requests.
- Tracks the linked word address and decides each SC's success.
- Gates the SC memory write and supplies the SC result (1/0) for the rt writeback.
- Sits between the MEM stage and the MEM/WB register. Its LLbit write outputs travel down the pipeline to the LLbit register.

Parameters:
ADDR_WIDTH, 32, data-address width; word granule compares bits [ADDR_WIDTH-1:2].
TIMEOUT_CYCLES, 1024, reservation lifetime in cycles when LLSC_TIMEOUT_EN is defined; minimum 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
flush  input  1  pipeline flush (exception/ERET); kills the reservation
stall  input  1  MEM stage stalled; state and address registers hold
mem_valid  input  1  a valid instruction is in MEM
mem_op  input  2  00 none, 01 LL, 10 SC, 11 ordinary store
mem_addr  input  ADDR_WIDTH  effective address of the MEM instruction
mem_we_in  input  1  store write-enable from the MEM decode
LLbit_value  input  1  current LLbit register output
wb_LLbit_write_enable  input  1  WB-stage LLbit write pending (forwarding)
wb_LLbit_value  input  1  WB-stage LLbit write value
snoop_valid  input  1  another master wrote memory this cycle
snoop_addr  input  ADDR_WIDTH  address of that write
mem_we_out  output  1  gated memory write-enable
sc_result  output  1  value written to rt by SC (1 success, 0 fail)
LLbit_write_enable  output  1  LLbit write request to the MEM/WB register
LLbit_write_value  output  1  value for that write
link_valid  output  1  reservation state is LINKED
link_addr  output  ADDR_WIDTH-2  registered linked word address

Behaviour:
- Effective LLbit (eff) is wb_LLbit_value if wb_LLbit_write_enable, else LLbit_value.
- A "hit" means addr[ADDR_WIDTH-1:2] equals link_addr.
- State machine (registered, updates on posedge clock):
  - IDLE: LL (mem_valid, not stall, not flush) -> LINKED; link_addr <= mem_addr[ADDR_WIDTH-1:2].
  - LINKED -> IDLE on any of: SC (success or fail); own ordinary store that hits; snoop_valid that hits; flush.
  - LINKED + LL: stay LINKED and reload link_addr.
- Priority: reset > flush > stall > LL > SC / store / snoop clear.
- Same-cycle conflicts:
  - Snoop hit in the same cycle as an LL to that address: LL wins, ends LINKED.
  - Snoop hit in the same cycle as an SC: that SC fails.
- Stall: the state and link_addr registers hold. A snoop hit during stall still clears LINKED, so snoops are never lost.
- Combinational outputs, zero latency in the MEM cycle; all are 0 when mem_valid=0 or flush=1:
  - LL: LLbit_write_enable=1, LLbit_write_value=1, mem_we_out=0, sc_result=0.
  - SC: success = eff & link_valid & hit(mem_addr) & no same-cycle snoop hit.
    - mem_we_out = mem_we_in & success; sc_result = success.
    - LLbit_write_enable=1, LLbit_write_value=0.
  - Ordinary store: mem_we_out = mem_we_in; LLbit_write_enable = 1 only if it hits while LINKED, with value 0.
  - Snoop hit while LINKED and MEM is not an LL: LLbit_write_enable=1, value 0.
- Reset: state IDLE, link_addr 0, link_valid 0. All combinational outputs are 0 while reset=1.
- Reset during an in-flight SC: the SC is squashed, with no write and sc_result 0.

Optional Feature:
LLSC_TIMEOUT_EN.
- Defined: a counter of width clog2(TIMEOUT_CYCLES)
  - loads 0 on entry to LINKED, including an LL reload;
  - increments each non-stalled cycle.
- When the counter reaches TIMEOUT_CYCLES-1 the unit goes to IDLE and issues LLbit_write_enable=1, value 0 (lower priority than an LL in the same cycle).
  - An SC after expiry fails.
- Undefined: no counter; the reservation persists indefinitely.

Test Plan:
- LL 0x100, next cycle SC 0x100 with eff=1, mem_we_in=1 -> mem_we_out=1, sc_result=1, LLbit write 0, link_valid falls.
- LL 0x100, snoop_valid with snoop_addr=0x102 (same word), then SC 0x100 -> sc_result=0, mem_we_out=0.
- LL 0x100, SC 0x104 -> fail, sc_result=0, link_valid=0.
- LL 0x200 with flush=1 in the same cycle -> no LLbit write, state stays IDLE; a following SC 0x200 fails.
- SC while wb_LLbit_write_enable=1, wb_LLbit_value=0 and LLbit_value=1, link valid on the same address -> forwarding forces a fail.
- LLSC_TIMEOUT_EN with TIMEOUT_CYCLES=8: LL, then 8 idle cycles -> LLbit write 0 at cycle 7 and a later SC fails; SC at cycle 5 succeeds.
